arf_sequencer: RTL
==================

Name: arf_sequencer

Overview:
- Control sequencer for the address register file (PC, AR, SP).
- Accepts one operation request at a time over a valid/ready handshake and expands it into 1-3 cycles of ARF control: FunSel, RegSel, OutCSel, OutDSel.
- Also drives memory-strobe qualifiers, so fetch, stack and call micro-sequences are generated in one place.
- Sits between the instruction control unit and the ARF.

Parameters:
- CNT_W, 8, width of the completed-operation counter OpCount.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- ReqValid  input  1  request present.
- ReqOp  input  3  operation code, sampled on accept.
- ReqReady  output  1  sequencer can accept; high only in IDLE.
- Done  output  1  high during the final step cycle of an operation.
- ARF_FunSel  output  3  to ARF FunSel. 000 decrement, 001 increment, 010 load, 011 clear.
- ARF_RegSel  output  3  to ARF RegSel. Active-low enables, bit2=PC, bit1=AR, bit0=SP.
- ARF_OutCSel  output  2  to ARF OutCSel. 00 PC, 10 AR, 11 SP.
- ARF_OutDSel  output  2  to ARF OutDSel, same encoding.
- MemAddrValid  output  1  ARF OutD is a valid memory address this cycle.
- MemWrite  output  1  with MemAddrValid: write, data taken from OutC.
- OpCount  output  CNT_W  number of completed operations, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- State machine: IDLE, S1, S2, S3.
- Accept: ReqValid && ReqReady in IDLE latches ReqOp, next state S1. Without an accept, IDLE holds.
- Output timing: outputs are a Moore decode of the state and the latched op. ARF registers update at the clock edge that ends a step cycle.
- Idle defaults (IDLE and any unlisted field): RegSel=111, FunSel=000, OutCSel=00, OutDSel=00, MemAddrValid=0, MemWrite=0, Done=0.
- Op steps (last listed step asserts Done, then the next state is IDLE):
  - 000 NOP — S1: defaults only.
  - 001 FETCH — S1: OutDSel=00, MemAddrValid=1. S2: RegSel=011, FunSel=001 (PC+1).
  - 010 PUSH — S1: OutDSel=11, MemAddrValid=1, MemWrite=1. S2: RegSel=110, FunSel=000 (SP-1).
  - 011 POP — S1: RegSel=110, FunSel=001 (SP+1). S2: OutDSel=11, MemAddrValid=1.
  - 100 JUMP — S1: RegSel=011, FunSel=010 (PC loads ARF I).
  - 101 LDAR — S1: RegSel=101, FunSel=010.
  - 110 CALL — S1: OutCSel=00, OutDSel=11, MemAddrValid=1, MemWrite=1. S2: RegSel=110, FunSel=000. S3: RegSel=011, FunSel=010.
  - 111 CLRALL — S1: RegSel=000, FunSel=011.
- Latency: accept-to-Done is 1 (NOP/JUMP/LDAR/CLRALL), 2 (FETCH/PUSH/POP) or 3 (CALL) cycles.
- ReqReady returns high the cycle after Done, so the minimum issue interval is latency+1.
- ReqOp and ReqValid changes during S1-S3 are ignored. The latched op is stable until IDLE.
- Never more than one RegSel bit pattern per cycle. MemWrite is never 1 while MemAddrValid is 0.
- OpCount increments at the clock edge ending any Done cycle. Wrap from 2^CNT_W-1 to 0.
- Reset, including mid-operation: state=IDLE, all outputs at idle defaults, OpCount=0, ReqReady=1 after reset deasserts. A partially executed op is abandoned, with no further ARF enables; the ARF contents are not restored.

Test Plan:
- Reset, then FETCH accepted at cycle 0 -> cycle 1: OutDSel=00, MemAddrValid=1. Cycle 2: RegSel=011, FunSel=001, Done=1. Cycle 3: ReqReady=1, OpCount=1.
- CALL with ReqValid held high and ReqOp=110 -> S1 MemWrite=1 with OutCSel=00, OutDSel=11. S2 RegSel=110, FunSel=000. S3 RegSel=011, FunSel=010, Done=1. Second CALL accepted at cycle 4.
- PUSH then POP back-to-back -> PUSH: address SP strobe, then SP decrement. POP: SP increment, then address SP strobe. OpCount=2. With a model ARF SP=0x0100, SP ends at 0x0100.
- ReqOp changed from 001 to 111 in S1 of FETCH -> FETCH sequence unchanged, no RegSel=000 cycle.
- Reset asserted in S2 of CALL -> immediately RegSel=111, MemAddrValid=0, Done=0, OpCount=0. No PC load occurs.
- CNT_W=2, issue 5 JUMPs -> OpCount sequence 1, 2, 3, 0, 1. Each JUMP asserts RegSel=011, FunSel=010 for exactly one cycle.

Source files
------------

// File: rtl/arf_sequencer.sv
// arf_sequencer: expands one ARF operation request into 1-3 control steps.
// Ports: Clock/Reset, ReqValid/ReqOp/ReqReady handshake, Done, ARF_* selects,
// MemAddrValid/MemWrite strobe qualifiers, OpCount completed-op counter.
module arf_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  input  logic [2:0]       ReqOp,
  output logic             ReqReady,
  output logic             Done,
  output logic [2:0]       ARF_FunSel,
  output logic [2:0]       ARF_RegSel,
  output logic [1:0]       ARF_OutCSel,
  output logic [1:0]       ARF_OutDSel,
  output logic             MemAddrValid,
  output logic             MemWrite,
  output logic [CNT_W-1:0] OpCount
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_FETCH  = 3'b001;
  localparam logic [2:0] OP_PUSH   = 3'b010;
  localparam logic [2:0] OP_POP    = 3'b011;
  localparam logic [2:0] OP_JUMP   = 3'b100;
  localparam logic [2:0] OP_LDAR   = 3'b101;
  localparam logic [2:0] OP_CALL   = 3'b110;
  localparam logic [2:0] OP_CLRALL = 3'b111;

  localparam logic [2:0] FS_DEC = 3'b000;
  localparam logic [2:0] FS_INC = 3'b001;
  localparam logic [2:0] FS_LD  = 3'b010;
  localparam logic [2:0] FS_CLR = 3'b011;

  // RegSel enables are active-low: bit2=PC, bit1=AR, bit0=SP.
  localparam logic [2:0] RS_NONE = 3'b111;
  localparam logic [2:0] RS_PC   = 3'b011;
  localparam logic [2:0] RS_AR   = 3'b101;
  localparam logic [2:0] RS_SP   = 3'b110;
  localparam logic [2:0] RS_ALL  = 3'b000;

  localparam logic [1:0] SEL_PC = 2'b00;
  localparam logic [1:0] SEL_SP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] op_q;
  logic       accept;
  logic       last_step;

  assign accept = ReqValid && (state == IDLE);

  // State register; the op is only captured on accept so it stays
  // stable for the whole sequence regardless of ReqOp activity.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      op_q  <= OP_NOP;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q <= ReqOp;
      end
    end
  end

  // Which step is the final one for the latched op.
  always_comb begin
    last_step = 1'b0;
    unique case (state)
      IDLE: last_step = 1'b0;
      S1: begin
        unique case (op_q)
          OP_NOP, OP_JUMP,
          OP_LDAR, OP_CLRALL: last_step = 1'b1;
          default:            last_step = 1'b0;
        endcase
      end
      S2:      last_step = (op_q != OP_CALL);
      S3:      last_step = 1'b1;
      default: last_step = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = accept ? S1 : IDLE;
      S1:      state_nxt = last_step ? IDLE : S2;
      S2:      state_nxt = last_step ? IDLE : S3;
      S3:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode from state and latched op.
  always_comb begin
    ReqReady     = (state == IDLE);
    Done         = last_step;
    ARF_FunSel   = FS_DEC;
    ARF_RegSel   = RS_NONE;
    ARF_OutCSel  = SEL_PC;
    ARF_OutDSel  = SEL_PC;
    MemAddrValid = 1'b0;
    MemWrite     = 1'b0;
    unique case (state)
      IDLE: begin
      end
      S1: begin
        unique case (op_q)
          OP_NOP: begin
          end
          OP_FETCH: begin
            ARF_OutDSel  = SEL_PC;
            MemAddrValid = 1'b1;
          end
          OP_PUSH: begin
            ARF_OutDSel  = SEL_SP;
            MemAddrValid = 1'b1;
            MemWrite     = 1'b1;
          end
          OP_POP: begin
            ARF_RegSel = RS_SP;
            ARF_FunSel = FS_INC;
          end
          OP_JUMP: begin
            ARF_RegSel = RS_PC;
            ARF_FunSel = FS_LD;
          end
          OP_LDAR: begin
            ARF_RegSel = RS_AR;
            ARF_FunSel = FS_LD;
          end
          OP_CALL: begin
            // Return address (PC on OutC) written to the stack slot.
            ARF_OutCSel  = SEL_PC;
            ARF_OutDSel  = SEL_SP;
            MemAddrValid = 1'b1;
            MemWrite     = 1'b1;
          end
          OP_CLRALL: begin
            ARF_RegSel = RS_ALL;
            ARF_FunSel = FS_CLR;
          end
          default: begin
          end
        endcase
      end
      S2: begin
        unique case (op_q)
          OP_FETCH: begin
            ARF_RegSel = RS_PC;
            ARF_FunSel = FS_INC;
          end
          OP_PUSH, OP_CALL: begin
            ARF_RegSel = RS_SP;
            ARF_FunSel = FS_DEC;
          end
          OP_POP: begin
            ARF_OutDSel  = SEL_SP;
            MemAddrValid = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S3: begin
        if (op_q == OP_CALL) begin
          ARF_RegSel = RS_PC;
          ARF_FunSel = FS_LD;
        end
      end
      default: begin
      end
    endcase
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      OpCount <= '0;
    end else if (Done) begin
      OpCount <= OpCount + 1'b1;
    end
  end

endmodule
